reg_display_scanner: RTL and testbench
======================================

Name: reg_display_scanner

Overview:
- Front-panel viewer that sits directly downstream of the register file's display read port.
- Drives the 5-bit display read address, captures the returned 32-bit register value, and decodes it to eight active-low 7-segment hex digits.
- Two push buttons step the viewed register up or down, with debouncing and wrap-around.
- Purely observational: never touches the register file's write path.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level change is accepted (10 ms at 50 MHz); minimum 2.
- SCAN_CYCLES, 50000000, auto-scan dwell per register in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets the block.
- btn_next_n  input  1  raw push button, active-low, asynchronous to clk; press selects the next register.
- btn_prev_n  input  1  raw push button, active-low, asynchronous to clk; press selects the previous register.
- display_read_addr  output  5  register index presented to the register file display port.
- display_read_data  input  32  combinational register value returned for display_read_addr.
- hex0..hex7  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 shows data bits [3:0], hex7 shows bits [31:28].
- addr_led  output  5  copy of display_read_addr for board LEDs.

Behaviour:
- Reset values (reset=0 at a clk edge):
  - display_read_addr = 0 and addr_led = 0.
  - Capture register = 0; every hexN = 7'b1000000 (glyph "0").
  - Debounced button states = released; debounce counters = 0; auto-scan counter = 0.
- Reset always wins over any simultaneous event. Reset held for one cycle mid-debounce discards the partial count.
- Input synchronisation: each button passes through a 2-flop synchroniser before any use. Raw inputs never reach logic directly.
- Debounce, per button, as a 2-state FSM:
  - RELEASED and PRESSED.
  - Counter increments while the synchronised level differs from the current state.
  - Counter clears to 0 on any cycle where the levels agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the state flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are therefore ignored.
- Press event: a one-cycle pulse on the RELEASED->PRESSED transition only. Release produces no event; holding a button does not repeat.
- Address update, registered:
  - next event only: addr+1; 31 wraps to 0.
  - prev event only: addr-1; 0 wraps to 31.
  - Both events in the same cycle: address unchanged.
- The address changes on the clock edge after the event pulse.
- Capture register: loads display_read_data every cycle (1-cycle latency).
- Hex outputs: registered decode of the capture register, digits 0-9 and A-F, using the standard active-low DE-board glyphs. A changes to 7'b0001000 and F to 7'b0001110.
- Latency from display_read_data changing to the hex outputs changing: 2 cycles.
- Latency from an address change to the new value on the hex outputs: 2 cycles, because the register file read port is combinational.
- Register 0: shown as whatever the port returns. No special-casing in this block.
- Arithmetic: 5-bit modulo-32 throughout the address path; no width extension.

Optional Feature:
- Macro: REG_DISPLAY_AUTOSCAN_EN.
- Defined:
  - A free-running counter counts 0..SCAN_CYCLES-1.
  - At terminal count the address advances by +1 (wrapping 31->0) and the counter clears.
  - Any button event also clears the counter and takes priority over the auto-advance in that cycle.
  - Net effect: the display dwells a full SCAN_CYCLES after each manual step.
- Not defined: no auto-scan counter exists; the address changes only through button events. The SCAN_CYCLES parameter is accepted but unused.

Test Plan:
- Reset and decode: DEBOUNCE_CYCLES=4, reset=0 for 2 cycles, display_read_data=32'h0 -> addr=0 and all hex=7'b1000000. Then release reset, drive data=32'h1234ABCF -> after 2 cycles hex7..hex0 show 1,2,3,4,A,B,C,F.
- Debounce and step: hold btn_next_n=0 for 10 cycles, then release -> addr 0->1 exactly once, no repeat while held. A 2-cycle low glitch -> addr unchanged.
- Wrap-around: at addr=31, press next -> addr=0; then press prev -> addr=31.
- Simultaneous presses: both buttons pressed with identical timing -> addr unchanged. Pressing next alone afterward -> addr+1.
- Reset mid-debounce: hold next for 2 of 4 cycles, pulse reset=0 for one cycle, keep holding for 3 more cycles -> no step. The step occurs only after 4 further stable cycles.
- Auto-scan (REG_DISPLAY_AUTOSCAN_EN, SCAN_CYCLES=8): idle 24 cycles -> addr 0->3. A next press at count 5 resets the dwell, so the next auto-advance comes 8 cycles after the manual step.

Source files
------------

// File: rtl/reg_display_scanner.sv
// reg_display_scanner: debounced register-file viewer driving eight active-low 7-segment hex digits.
// Define REG_DISPLAY_AUTOSCAN_EN to also step the address every SCAN_CYCLES cycles.
module reg_display_scanner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next_n,
    input  logic        btn_prev_n,
    output logic [4:0]  display_read_addr,
    input  logic [31:0] display_read_data,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic [4:0]  addr_led
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic {RELEASED, PRESSED} db_state_t;

    logic [1:0]  btn_n;
    logic [1:0]  btn_ev;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] cap_q;
    logic [6:0]  hex_q [8];

    assign btn_n = {btn_prev_n, btn_next_n};

    // Empty marker block for illegal parameter values; SCAN_CYCLES matters only with auto-scan.
    if (DEBOUNCE_CYCLES < 2 || SCAN_CYCLES < 1) begin : g_bad_params
    end

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic [1:0]    sync_q;
        db_state_t     st_q, st_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          differ, flip, ev_q;
        always_comb begin
            differ = (~sync_q[1]) != (st_q == PRESSED);
            flip   = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
            st_d   = flip ? (st_q == PRESSED ? RELEASED : PRESSED) : st_q;
            cnt_d  = (!differ || flip) ? '0 : cnt_q + 1'b1;
        end
        always_ff @(posedge clk) begin
            if (!reset) begin
                sync_q <= 2'b11;
                st_q   <= RELEASED;
                cnt_q  <= '0;
                ev_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], btn_n[g]};
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                ev_q   <= flip && (st_q == RELEASED);
            end
        end
        assign btn_ev[g] = ev_q;
    end

`ifdef REG_DISPLAY_AUTOSCAN_EN
    localparam int SW = $clog2(SCAN_CYCLES + 1);
    logic [SW-1:0] scan_q, scan_d;
    logic          scan_tc;
    always_comb begin
        scan_tc = scan_q == SW'(SCAN_CYCLES - 1);
        scan_d  = (|btn_ev || scan_tc) ? '0 : scan_q + 1'b1;
        addr_d  = (btn_ev == 2'b01) ? addr_q + 5'd1 :
                  (btn_ev == 2'b10) ? addr_q - 5'd1 :
                  (btn_ev == 2'b00 && scan_tc) ? addr_q + 5'd1 : addr_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) scan_q <= '0;
        else        scan_q <= scan_d;
    end
`else
    always_comb begin
        addr_d = (btn_ev == 2'b01) ? addr_q + 5'd1 :
                 (btn_ev == 2'b10) ? addr_q - 5'd1 : addr_q;
    end
`endif

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
            cap_q  <= '0;
            for (int i = 0; i < 8; i++) hex_q[i] <= 7'b1000000;
        end else begin
            addr_q <= addr_d;
            cap_q  <= display_read_data;
            for (int i = 0; i < 8; i++) hex_q[i] <= seg(cap_q[4*i +: 4]);
        end
    end

    assign display_read_addr = addr_q;
    assign addr_led          = addr_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];
endmodule

// File: tb/tb_reg_display_scanner.sv
// tb_reg_display_scanner: scoreboard bench; a register-file model feeds the read port and
// expected address/glyphs are queued with a due cycle and checked by a separate monitor.
module tb_reg_display_scanner;
    localparam int D = 4;
    localparam int S = 8;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 1'b0, reset = 1'b0, btn_next_n = 1'b1, btn_prev_n = 1'b1;
    logic [4:0]  display_read_addr, addr_led;
    logic [31:0] display_read_data;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [31:0] regfile [32];
    logic [4:0]  m_addr = '0;
    int cyc = 0, n_cmp = 0, n_bad = 0;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] word;
        string       name;
    } exp_t;
    exp_t sb[$];

    reg_display_scanner #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .btn_next_n(btn_next_n), .btn_prev_n(btn_prev_n),
        .display_read_addr(display_read_addr), .display_read_data(display_read_data),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7), .addr_led(addr_led));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign display_read_data = regfile[display_read_addr];

    function automatic logic [55:0] glyphs(input logic [31:0] w);
        logic [55:0] r;
        for (int i = 0; i < 8; i++) r[7*i +: 7] = GLYPH[w[4*i +: 4]];
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                n_cmp++;
                if (display_read_addr !== sb[i].addr || addr_led !== sb[i].addr) begin
                    n_bad++;
                    $display("FAIL %s addr: got %0d led %0d, want %0d", sb[i].name,
                             display_read_addr, addr_led, sb[i].addr);
                end
                n_cmp++;
                if ({hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} !== glyphs(sb[i].word)) begin
                    n_bad++;
                    $display("FAIL %s hex: got %h, want %h (word %h)", sb[i].name,
                             {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0},
                             glyphs(sb[i].word), sb[i].word);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int lat, input logic [4:0] a, input logic [31:0] w, input string name);
        exp_t e;
        e.due = cyc + lat;
        e.addr = a;
        e.word = w;
        e.name = name;
        sb.push_back(e);
    endtask

    // Low for len cycles; a press counts once if it stays low for at least D cycles.
    task automatic press(input bit nx, input bit pv, input int len, input string name);
        btn_next_n = !nx;
        btn_prev_n = !pv;
        tick(len);
        btn_next_n = 1'b1;
        btn_prev_n = 1'b1;
        if (len >= D) m_addr = (nx && !pv) ? m_addr + 5'd1 : (pv && !nx) ? m_addr - 5'd1 : m_addr;
        tick(14);
        expect_at(0, m_addr, regfile[m_addr], name);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = '0;
        tick(2);
        expect_at(0, 5'd0, 32'h0, "reset");
        tick(1);
        for (int i = 1; i < 32; i++) regfile[i] = $urandom;
        reset = 1'b1;
        regfile[0] = 32'h1234ABCF;
        expect_at(1, 5'd0, 32'h0, "decode_early");
        expect_at(2, 5'd0, 32'h1234ABCF, "decode");
        tick(3);
`ifdef REG_DISPLAY_AUTOSCAN_EN
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        expect_at(7, 5'd0, regfile[0], "scan_before_first");
        expect_at(26, 5'd3, regfile[3], "scan_idle_24");
        tick(30);
`else
        press(1, 0, 10, "hold_next");
        press(1, 0, 2, "glitch");
        press(1, 0, D, "exact_len");
        press(1, 0, D - 1, "short_len");
        while (m_addr != 5'd0) press(0, 1, 6, "walk_down");
        press(0, 1, 6, "wrap_prev");
        press(1, 0, 6, "wrap_next");
        press(0, 1, 6, "wrap_prev2");
        press(1, 1, 6, "both");
        press(1, 0, 6, "next_after_both");
        btn_next_n = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(3);
        btn_next_n = 1'b1;
        m_addr = 5'd0;
        tick(14);
        expect_at(0, m_addr, regfile[m_addr], "rst_mid");
        press(1, 0, D, "after_rst");
        for (int i = 0; i < 20; i++) begin
            press(1'($urandom), 1'($urandom), $urandom_range(1, 3 * D), "rand_press");
        end
        for (int i = 0; i < 40; i++) begin
            regfile[m_addr] = $urandom;
            expect_at(2, m_addr, regfile[m_addr], "data_stream");
            tick(1);
        end
        tick(3);
`endif
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
